// File: rtl/pwrgood_seq.sv
// Power-on sequencer: qualifies board power-OK and PLL lock and produces the
// active-low power-good-n, with glitch filtering, minimum off-time and a sticky fault flag.
module pwrgood_seq #(
  parameter int SYNC_STAGES    = 2,
  parameter int STABLE_CYCLES  = 1024,
  parameter int FAULT_FILTER   = 4,
  parameter int MIN_OFF_CYCLES = 256
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       board_pwr_ok_i,
  input  logic       pll_locked_i,
  input  logic       fault_clr,
  output logic       pwr_good_n,
  output logic       pwr_stable,
  output logic       fault_sticky,
  output logic [1:0] seq_state
);

  localparam int MAX_AB  = (STABLE_CYCLES > FAULT_FILTER) ? STABLE_CYCLES : FAULT_FILTER;
  localparam int MAX_CNT = (MAX_AB > MIN_OFF_CYCLES) ? MAX_AB : MIN_OFF_CYCLES;
  localparam int CW      = $clog2(MAX_CNT + 1);

  localparam logic [CW-1:0] STABLE_LAST = CW'(STABLE_CYCLES - 1);
  localparam logic [CW-1:0] FILTER_LAST = CW'(FAULT_FILTER - 1);
  localparam logic [CW-1:0] OFF_LAST    = CW'(MIN_OFF_CYCLES - 1);

  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("pwrgood_seq: SYNC_STAGES must be >= 2");
  end
  if (STABLE_CYCLES < 1) begin : g_bad_stable
    $error("pwrgood_seq: STABLE_CYCLES must be >= 1");
  end
  if (FAULT_FILTER < 1) begin : g_bad_filter
    $error("pwrgood_seq: FAULT_FILTER must be >= 1");
  end
  if (MIN_OFF_CYCLES < 1) begin : g_bad_off
    $error("pwrgood_seq: MIN_OFF_CYCLES must be >= 1");
  end

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    STABILIZE = 2'd1,
    GOOD      = 2'd2,
    FAULT     = 2'd3
  } state_t;

  state_t                 state, state_next;
  logic [CW-1:0]          cnt, cnt_next;
  logic [SYNC_STAGES-1:0] pwr_sync, pll_sync;
  logic                   ok_s;
  logic                   enter_fault;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pwr_sync <= '0;
      pll_sync <= '0;
    end else begin
      pwr_sync <= {pwr_sync[SYNC_STAGES-2:0], board_pwr_ok_i};
      pll_sync <= {pll_sync[SYNC_STAGES-2:0], pll_locked_i};
    end
  end

  assign ok_s = pwr_sync[SYNC_STAGES-1] & pll_sync[SYNC_STAGES-1];

  // The shared counter is cleared on every transition, so each state starts counting from zero.
  always_comb begin
    state_next  = state;
    cnt_next    = cnt;
    enter_fault = 1'b0;
    case (state)
      IDLE: begin
        if (ok_s) begin
          state_next = STABILIZE;
          cnt_next   = '0;
        end
      end
      STABILIZE: begin
        if (!ok_s) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else if (cnt == STABLE_LAST) begin
          state_next = GOOD;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + CW'(1);
        end
      end
      GOOD: begin
        if (ok_s) begin
          cnt_next = '0;
        end else if (cnt == FILTER_LAST) begin
          state_next  = FAULT;
          cnt_next    = '0;
          enter_fault = 1'b1;
        end else begin
          cnt_next = cnt + CW'(1);
        end
      end
      FAULT: begin
        if (cnt == OFF_LAST) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + CW'(1);
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // A fault arriving in the same cycle as a clear request must not be lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fault_sticky <= 1'b0;
    end else if (enter_fault) begin
      fault_sticky <= 1'b1;
    end else if (fault_clr) begin
      fault_sticky <= 1'b0;
    end
  end

  assign pwr_good_n = (state != GOOD);
  assign pwr_stable = (state == STABILIZE);
  assign seq_state  = state;

endmodule

// File: tb/tb_pwrgood_seq.sv
// Self-checking bench for pwrgood_seq: directed scenarios followed by random input
// segments, all compared every cycle against a run-length based reference model.
module tb_pwrgood_seq;

  localparam int SYNC_STAGES    = 2;
  localparam int STABLE_CYCLES  = 8;
  localparam int FAULT_FILTER   = 3;
  localparam int MIN_OFF_CYCLES = 5;

  logic       clk = 1'b0;
  logic       rst;
  logic       board_pwr_ok_i;
  logic       pll_locked_i;
  logic       fault_clr;
  logic       pwr_good_n;
  logic       pwr_stable;
  logic       fault_sticky;
  logic [1:0] seq_state;

  int checks_total  = 0;
  int checks_passed = 0;
  int checks_failed = 0;

  pwrgood_seq #(
    .SYNC_STAGES   (SYNC_STAGES),
    .STABLE_CYCLES (STABLE_CYCLES),
    .FAULT_FILTER  (FAULT_FILTER),
    .MIN_OFF_CYCLES(MIN_OFF_CYCLES)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .board_pwr_ok_i(board_pwr_ok_i),
    .pll_locked_i  (pll_locked_i),
    .fault_clr     (fault_clr),
    .pwr_good_n    (pwr_good_n),
    .pwr_stable    (pwr_stable),
    .fault_sticky  (fault_sticky),
    .seq_state     (seq_state)
  );

  always #5 clk = ~clk;

  // Model: lengths of the current high run (qualifying), low run (in good) and remaining off-time.
  typedef struct {
    int                     off_left;
    int                     up_run;
    int                     low_run;
    bit                     is_good;
    bit                     sticky;
    bit [SYNC_STAGES-1:0]   hist;
  } model_t;

  model_t m;

  function automatic model_t modelReset();
    model_t r;
    r.off_left = 0;
    r.up_run   = 0;
    r.low_run  = 0;
    r.is_good  = 1'b0;
    r.sticky   = 1'b0;
    r.hist     = '0;
    return r;
  endfunction

  function automatic model_t modelStep(input model_t s, input logic pwr, input logic pll,
                                       input logic clr);
    model_t r;
    bit     ok_seen;
    bit     set_now;
    r       = s;
    set_now = 1'b0;
    ok_seen = s.hist[SYNC_STAGES-1];
    r.hist  = {s.hist[SYNC_STAGES-2:0], bit'(pwr & pll)};
    if (s.off_left > 0) begin
      r.off_left = s.off_left - 1;
      r.up_run   = 0;
    end else if (s.is_good) begin
      if (ok_seen) begin
        r.low_run = 0;
      end else begin
        r.low_run = s.low_run + 1;
        if (r.low_run == FAULT_FILTER) begin
          r.is_good  = 1'b0;
          r.low_run  = 0;
          r.off_left = MIN_OFF_CYCLES;
          set_now    = 1'b1;
        end
      end
    end else if (ok_seen) begin
      r.up_run = s.up_run + 1;
      if (r.up_run == STABLE_CYCLES + 1) begin
        r.is_good = 1'b1;
        r.up_run  = 0;
        r.low_run = 0;
      end
    end else begin
      r.up_run = 0;
    end
    if (set_now) r.sticky = 1'b1;
    else if (clr) r.sticky = 1'b0;
    return r;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) m <= modelReset();
    else     m <= modelStep(m, board_pwr_ok_i, pll_locked_i, fault_clr);
  end

  function automatic logic [1:0] expState();
    if (m.off_left > 0) return 2'd3;
    if (m.is_good)      return 2'd2;
    if (m.up_run > 0)   return 2'd1;
    return 2'd0;
  endfunction

  task automatic checkValue(input string tag, input logic [1:0] observed,
                            input logic [1:0] expected);
    checks_total++;
    assert (observed === expected) checks_passed++;
    else begin
      checks_failed++;
      $error("[TB] FAIL %s at %0t: observed=%0d expected=%0d", tag, $time, observed, expected);
    end
  endtask

  task automatic checkOutput(input string tag);
    logic [1:0] st;
    st = expState();
    checkValue({tag, ".seq_state"},    seq_state,           st);
    checkValue({tag, ".pwr_good_n"},   {1'b0, pwr_good_n},   {1'b0, st != 2'd2});
    checkValue({tag, ".pwr_stable"},   {1'b0, pwr_stable},   {1'b0, st == 2'd1});
    checkValue({tag, ".fault_sticky"}, {1'b0, fault_sticky}, {1'b0, m.sticky});
  endtask

  task automatic applyStimulus(input logic pwr, input logic pll, input logic clr,
                               input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      checkOutput(tag);
      board_pwr_ok_i = pwr;
      pll_locked_i   = pll;
      fault_clr      = clr;
    end
  endtask

  initial begin
    int seg_len;
    int pick;
    rst            = 1'b1;
    board_pwr_ok_i = 1'b0;
    pll_locked_i   = 1'b0;
    fault_clr      = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset");
    checkValue("reset.pgn_const", {1'b0, pwr_good_n}, 2'd1);
    rst = 1'b0;

    $display("[TB] power-up");
    applyStimulus(1'b1, 1'b1, 1'b0, 11, "pwrup");
    checkValue("pwrup.last_stab", seq_state, 2'd1);
    applyStimulus(1'b1, 1'b1, 1'b0, 1, "pwrup");
    checkValue("pwrup.good", seq_state, 2'd2);
    checkValue("pwrup.pgn_low", {1'b0, pwr_good_n}, 2'd0);
    applyStimulus(1'b1, 1'b1, 1'b0, 3, "hold");

    $display("[TB] glitch filter");
    applyStimulus(1'b0, 1'b1, 1'b0, 2, "glitch");
    applyStimulus(1'b1, 1'b1, 1'b0, 6, "glitch");
    checkValue("glitch.pgn_low", {1'b0, pwr_good_n}, 2'd0);
    checkValue("glitch.sticky", {1'b0, fault_sticky}, 2'd0);

    $display("[TB] fault with clear collision");
    applyStimulus(1'b1, 1'b0, 1'b0, 4, "fault");
    applyStimulus(1'b1, 1'b0, 1'b1, 1, "fault_clr_same");
    applyStimulus(1'b1, 1'b0, 1'b0, 1, "fault");
    checkValue("fault.state", seq_state, 2'd3);
    checkValue("fault.sticky_set_wins", {1'b0, fault_sticky}, 2'd1);
    applyStimulus(1'b1, 1'b0, 1'b0, 8, "fault_off");
    checkValue("fault.back_idle", seq_state, 2'd0);
    applyStimulus(1'b1, 1'b0, 1'b1, 1, "clear");
    applyStimulus(1'b1, 1'b0, 1'b0, 1, "clear");
    checkValue("clear.sticky", {1'b0, fault_sticky}, 2'd0);
    checkValue("clear.state", seq_state, 2'd0);

    $display("[TB] stabilize abort at terminal count");
    applyStimulus(1'b1, 1'b1, 1'b0, 8, "abort");
    applyStimulus(1'b1, 1'b0, 1'b0, 1, "abort_pulse");
    applyStimulus(1'b1, 1'b1, 1'b0, 11, "rewindow");
    checkValue("rewindow.still_stab", seq_state, 2'd1);
    checkValue("rewindow.sticky", {1'b0, fault_sticky}, 2'd0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1, "rewindow");
    checkValue("rewindow.good", seq_state, 2'd2);

    $display("[TB] double drop and recovery");
    applyStimulus(1'b0, 1'b0, 1'b0, 6, "both_drop");
    applyStimulus(1'b1, 1'b1, 1'b0, 25, "recover");
    checkValue("recover.good", seq_state, 2'd2);
    checkValue("recover.sticky", {1'b0, fault_sticky}, 2'd1);

    $display("[TB] async reset mid-cycle");
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checkOutput("async_rst");
    checkValue("async_rst.pgn", {1'b0, pwr_good_n}, 2'd1);
    checkValue("async_rst.state", seq_state, 2'd0);
    checkValue("async_rst.sticky", {1'b0, fault_sticky}, 2'd0);
    board_pwr_ok_i = 1'b0;
    pll_locked_i   = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 4, "post_rst");
    checkValue("post_rst.idle", seq_state, 2'd0);

    $display("[TB] random segments");
    for (int s = 0; s < 60; s++) begin
      seg_len = $urandom_range(1, 15);
      pick    = $urandom_range(0, 9);
      for (int c = 0; c < seg_len; c++) begin
        if (pick < 6)
          applyStimulus(1'b1, 1'b1, ($urandom_range(0, 7) == 0), 1, "random");
        else
          applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                        ($urandom_range(0, 7) == 0), 1, "random");
      end
    end
    applyStimulus(1'b1, 1'b1, 1'b0, 1, "final");
    @(negedge clk);
    checkOutput("final");

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
